program_loader: RTL and testbench

Host-side sequencer that sits directly upstream of the multicycle CPU controller and owns its `start`/`done` handshake. It streams a program image byte-by-byte into the shared memory while the CPU is held in reset. It then releases the CPU, issues the single-cycle `start` pulse, runs the CPU for a programmed cycle budget and parks it back in reset. The CPU has no halt instruction, so this block is the only mechanism that bounds a run.

---
 rtl/loader_pkg.sv | 8 +
 rtl/budget_counter.sv | 19 +
 rtl/program_loader.sv | 100 ++++++++++
 tb/tb_program_loader.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding and default widths for the program loader.
package loader_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, WAITIDLE, STARTHI, RUN, STOP} state_t;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_CYC_WIDTH = 16;
    localparam int DEF_IDLE_TIMEOUT = 4;
endpackage

// File: rtl/budget_counter.sv
// budget_counter: loadable down-counter that flags the final cycle of a run budget.
module budget_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] value,
    output logic         expire
);
    logic [W-1:0] count;
    assign expire = count == W'(1);
    always_ff @(posedge clk or posedge rst)
        if (rst)
            count <= '0;
        else
            count <= load ? value : en ? count - W'(1) : count;
endmodule

// File: rtl/program_loader.sv
// program_loader: streams a program image into memory, then starts and bounds one CPU run.
module program_loader
    import loader_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int CYC_WIDTH = DEF_CYC_WIDTH,
    parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  loadReq,
    input  logic [ADDR_WIDTH-1:0] loadBase,
    input  logic [ADDR_WIDTH-1:0] loadLen,
    input  logic [CYC_WIDTH-1:0]  runBudget,
    input  logic                  abortReq,
    input  logic                  inValid,
    input  logic [DATA_WIDTH-1:0] inData,
    output logic                  inReady,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [DATA_WIDTH-1:0] memData,
    output logic                  memWrite,
    output logic                  cpuRst,
    output logic                  start,
    input  logic                  done,
    output logic                  busy,
    output logic                  finished,
    output logic                  error
);
    localparam int WW = $clog2(IDLE_TIMEOUT + 1);
    state_t state, nxt;
    logic [ADDR_WIDTH-1:0] base, len, idx;
    logic [CYC_WIDTH-1:0] budget;
    logic [WW-1:0] wcnt;
    logic hs, expire, abort_hit, timeout;
    assign inReady = state == LOAD && !abortReq;
    assign hs = inValid && inReady;
    assign abort_hit = abortReq && state inside {LOAD, WAITIDLE, STARTHI, RUN};
    assign timeout = state == WAITIDLE && !done && wcnt == WW'(IDLE_TIMEOUT - 1);
    assign start = state == STARTHI;
    assign busy = state != IDLE;
    assign finished = state == STOP;
    budget_counter #(.W(CYC_WIDTH)) u_budget (
        .clk    (clk),
        .rst    (rst),
        .load   (state == STARTHI),
        .en     (state == RUN && budget != '0),
        .value  (budget),
        .expire (expire)
    );
    always_comb begin
        nxt = state;
        if (abort_hit)
            nxt = STOP;
        else
            case (state)
                IDLE:     nxt = loadReq ? (loadLen != '0 ? LOAD : WAITIDLE) : IDLE;
                LOAD:     nxt = hs && idx == len - ADDR_WIDTH'(1) ? WAITIDLE : LOAD;
                WAITIDLE: nxt = done ? STARTHI : timeout ? STOP : WAITIDLE;
                STARTHI:  nxt = RUN;
                RUN:      nxt = budget != '0 && expire ? STOP : RUN;
                default:  nxt = IDLE;
            endcase
    end
    // cpuRst is held through the cycle carrying the final write so the CPU never sees a write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            base <= '0;
            len <= '0;
            idx <= '0;
            budget <= '0;
            wcnt <= '0;
            memAddr <= '0;
            memData <= '0;
            memWrite <= 1'b0;
            cpuRst <= 1'b1;
            error <= 1'b0;
        end else begin
            state <= nxt;
            memWrite <= hs;
            cpuRst <= !(nxt inside {WAITIDLE, STARTHI, RUN}) || hs;
            wcnt <= state == WAITIDLE ? wcnt + WW'(1) : '0;
            if (hs) begin
                memAddr <= base + idx;
                memData <= inData;
                idx <= idx + ADDR_WIDTH'(1);
            end
            if (state == IDLE && loadReq) begin
                base <= loadBase;
                len <= loadLen;
                budget <= runBudget;
                idx <= '0;
                error <= 1'b0;
            end
            if (abort_hit || timeout)
                error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed checks of loading, wrap, run budget, timeout, abort and reset.
module tb_program_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic loadReq = 1'b0;
    logic [11:0] loadBase = '0;
    logic [11:0] loadLen = '0;
    logic [15:0] runBudget = '0;
    logic abortReq = 1'b0;
    logic inValid = 1'b0;
    logic [7:0] inData = '0;
    logic inReady;
    logic [11:0] memAddr;
    logic [7:0] memData;
    logic memWrite, cpuRst, start, done = 1'b0, busy, finished, error;
    int nchk = 0;
    int nerr = 0;

    program_loader dut (
        .clk(clk), .rst(rst), .loadReq(loadReq), .loadBase(loadBase), .loadLen(loadLen),
        .runBudget(runBudget), .abortReq(abortReq), .inValid(inValid), .inData(inData),
        .inReady(inReady), .memAddr(memAddr), .memData(memData), .memWrite(memWrite),
        .cpuRst(cpuRst), .start(start), .done(done), .busy(busy), .finished(finished),
        .error(error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic session(input logic [11:0] b, input logic [11:0] l, input logic [15:0] bud);
        loadReq = 1'b1;
        loadBase = b;
        loadLen = l;
        runBudget = bud;
        tick();
        loadReq = 1'b0;
    endtask

    task automatic push(input logic [7:0] d, input logic [11:0] a);
        inValid = 1'b1;
        inData = d;
        tick();
        chk("wr_strobe", 32'(memWrite), 1);
        chk("wr_addr", 32'(memAddr), 32'(a));
        chk("wr_data", 32'(memData), 32'(d));
        chk("wr_cpurst", 32'(cpuRst), 1);
    endtask

    initial begin
        tick();
        chk("rst_cpurst", 32'(cpuRst), 1);
        chk("rst_outs", {memWrite, start, busy, finished, error, inReady}, 0);
        chk("rst_addr", 32'(memAddr), 0);
        rst = 1'b0;
        tick();
        // three back-to-back bytes, budget 2
        session(12'h010, 12'd3, 16'd2);
        chk("t1_busy", 32'(busy), 1);
        inValid = 1'b1;
        #1;
        chk("t1_ready", 32'(inReady), 1);
        push(8'hA1, 12'h010);
        push(8'hB2, 12'h011);
        push(8'hC3, 12'h012);
        inValid = 1'b0;
        done = 1'b1;
        tick();
        chk("t1_start", 32'(start), 1);
        chk("t1_cpurst_low", 32'(cpuRst), 0);
        chk("t1_nowrite", 32'(memWrite), 0);
        tick();
        chk("t1_start_pulse", 32'(start), 0);
        tick();
        chk("t1_run2", 32'(finished), 0);
        tick();
        chk("t1_fin", 32'(finished), 1);
        chk("t1_cpurst_back", 32'(cpuRst), 1);
        tick();
        chk("t1_idle", {busy, finished, error}, 0);
        // address wrap, budget 1
        session(12'hFFE, 12'd4, 16'd1);
        push(8'h11, 12'hFFE);
        push(8'h22, 12'hFFF);
        push(8'h33, 12'h000);
        push(8'h44, 12'h001);
        inValid = 1'b0;
        tick();
        chk("t2_start", 32'(start), 1);
        tick();
        chk("t2_run1", {start, busy, finished}, 3'b010);
        tick();
        chk("t2_fin", 32'(finished), 1);
        tick();
        // zero-length load, budget 5
        session(12'h000, 12'd0, 16'd5);
        chk("t3_cpurst", 32'(cpuRst), 0);
        chk("t3_nowrite", 32'(memWrite), 0);
        tick();
        chk("t3_start", 32'(start), 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_run", {start, finished, busy}, 3'b001);
        end
        tick();
        chk("t3_fin", 32'(finished), 1);
        chk("t3_cpurst_back", 32'(cpuRst), 1);
        chk("t3_noerr", 32'(error), 0);
        tick();
        chk("t3_idle", {busy, finished}, 0);
        // done never rises
        done = 1'b0;
        session(12'h000, 12'd0, 16'd5);
        for (int i = 0; i < 4; i++) begin
            chk("t4_wait", {start, finished, error, busy}, 4'b0001);
            tick();
        end
        chk("t4_fin", 32'(finished), 1);
        chk("t4_err", 32'(error), 1);
        chk("t4_nostart", 32'(start), 0);
        tick();
        chk("t4_err_sticky", {busy, error}, 2'b01);
        // unbounded run ended by abort
        done = 1'b1;
        session(12'h000, 12'd0, 16'd0);
        chk("t5_err_clr", 32'(error), 0);
        tick();
        tick();
        for (int i = 0; i < 19; i++) tick();
        chk("t5_still_run", {busy, finished, start}, 3'b100);
        abortReq = 1'b1;
        tick();
        abortReq = 1'b0;
        chk("t5_fin", 32'(finished), 1);
        chk("t5_err", 32'(error), 1);
        tick();
        // stalled stream with abort on a valid byte
        session(12'h100, 12'd2, 16'd3);
        chk("t6_err_clr", 32'(error), 0);
        tick();
        chk("t6_stall", 32'(memWrite), 0);
        push(8'h55, 12'h100);
        inValid = 1'b0;
        tick();
        chk("t6_gap", 32'(memWrite), 0);
        inValid = 1'b1;
        inData = 8'h66;
        abortReq = 1'b1;
        #1;
        chk("t6_ready_abort", 32'(inReady), 0);
        tick();
        inValid = 1'b0;
        abortReq = 1'b0;
        chk("t6_abort_nowrite", 32'(memWrite), 0);
        chk("t6_abort_stop", {finished, error}, 2'b11);
        tick();
        // asynchronous reset in the middle of a load
        session(12'h200, 12'd3, 16'd3);
        push(8'h77, 12'h200);
        #2;
        rst = 1'b1;
        #1;
        chk("t7_rst_outs", {memWrite, start, busy, finished, error, inReady}, 0);
        chk("t7_rst_addr", 32'(memAddr), 0);
        chk("t7_rst_data", 32'(memData), 0);
        chk("t7_rst_cpurst", 32'(cpuRst), 1);
        inValid = 1'b0;
        tick();
        rst = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
